// File: rtl/cp0_trap_ctrl.sv
// CP0 trap controller: owns SR/Cause/EPC/PRId, arbitrates interrupt, exception,
// ERET and MTC0 at M, and drives a one-cycle flush/redirect to the pipeline.
module cp0_trap_ctrl #(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] PRID_VAL   = 32'h0000_0601
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m_valid,
    input  logic [31:0] pc_m,
    input  logic        bd_m,
    input  logic        exc_m,
    input  logic [4:0]  exccode_m,
    input  logic        eret_m,
    input  logic [5:0]  hw_int,
    input  logic        mtc0_m,
    input  logic [4:0]  cp0_addr,
    input  logic [31:0] cp0_wdata,
    output logic [31:0] cp0_rdata,
    output logic        flush,
    output logic        redirect_en,
    output logic [31:0] redirect_pc,
    output logic [31:0] epc_out,
    output logic        in_trap
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  sr_im_q, sr_im_d;
    logic        sr_exl_q, sr_exl_d;
    logic        sr_ie_q, sr_ie_d;
    logic        cause_bd_q, cause_bd_d;
    logic [5:0]  cause_ip_q;
    logic [4:0]  cause_exc_q, cause_exc_d;
    logic [31:0] epc_q, epc_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        int_pend;

    assign int_pend = (|(cause_ip_q & sr_im_q)) & sr_ie_q & ~sr_exl_q;

    always_comb begin
        state_d       = ST_RUN;
        sr_im_d       = sr_im_q;
        sr_exl_d      = sr_exl_q;
        sr_ie_d       = sr_ie_q;
        cause_bd_d    = cause_bd_q;
        cause_exc_d   = cause_exc_q;
        epc_d         = epc_q;
        redirect_pc_d = redirect_pc_q;

        // While flushing, M is being cleared, so nothing from M is acted upon.
        if (state_q == ST_RUN && m_valid) begin
            if (int_pend || exc_m) begin
                state_d       = ST_FLUSH;
                epc_d         = bd_m ? (pc_m - 32'd4) : pc_m;
                cause_bd_d    = bd_m;
                cause_exc_d   = int_pend ? 5'd0 : exccode_m;
                sr_exl_d      = 1'b1;
                redirect_pc_d = HANDLER_PC;
            end else if (eret_m) begin
                state_d       = ST_FLUSH;
                sr_exl_d      = 1'b0;
                redirect_pc_d = epc_q;
            end else if (mtc0_m) begin
                case (cp0_addr)
                    ADDR_SR: begin
                        sr_im_d  = cp0_wdata[15:10];
                        sr_exl_d = cp0_wdata[1];
                        sr_ie_d  = cp0_wdata[0];
                    end
                    ADDR_EPC: epc_d = {cp0_wdata[31:2], 2'b00};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_RUN;
            sr_im_q       <= '0;
            sr_exl_q      <= 1'b0;
            sr_ie_q       <= 1'b0;
            cause_bd_q    <= 1'b0;
            cause_ip_q    <= '0;
            cause_exc_q   <= '0;
            epc_q         <= '0;
            redirect_pc_q <= '0;
        end else begin
            state_q       <= state_d;
            sr_im_q       <= sr_im_d;
            sr_exl_q      <= sr_exl_d;
            sr_ie_q       <= sr_ie_d;
            cause_bd_q    <= cause_bd_d;
            cause_ip_q    <= hw_int;
            cause_exc_q   <= cause_exc_d;
            epc_q         <= epc_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign flush       = (state_q == ST_FLUSH);
    assign redirect_en = (state_q == ST_FLUSH);
    assign redirect_pc = redirect_pc_q;
    assign epc_out     = epc_q;
    assign in_trap     = sr_exl_q;

    // Reads see register state only, so a same-cycle MTC0 is not bypassed.
    always_comb begin
        cp0_rdata = '0;
        case (cp0_addr)
            ADDR_SR:    cp0_rdata = {16'b0, sr_im_q, 8'b0, sr_exl_q, sr_ie_q};
            ADDR_CAUSE: cp0_rdata = {cause_bd_q, 15'b0, cause_ip_q, 3'b0, cause_exc_q, 2'b0};
            ADDR_EPC:   cp0_rdata = epc_q;
            ADDR_PRID:  cp0_rdata = PRID_VAL;
            default:    cp0_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_trap_ctrl.sv
// Self-checking bench for cp0_trap_ctrl: directed scenarios plus a randomized
// run, all checked against a register-level reference model.
module tb_cp0_trap_ctrl;

    localparam logic [31:0] HANDLER = 32'h0000_4180;
    localparam logic [31:0] PRID    = 32'h0000_0601;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        m_valid = 1'b0, bd_m = 1'b0, exc_m = 1'b0, eret_m = 1'b0, mtc0_m = 1'b0;
    logic [31:0] pc_m = '0, cp0_wdata = '0;
    logic [4:0]  exccode_m = '0, cp0_addr = '0;
    logic [5:0]  hw_int = '0;
    logic [31:0] cp0_rdata, redirect_pc, epc_out;
    logic        flush, redirect_en, in_trap;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: architectural registers as plain 32-bit words.
    logic [31:0] md_sr = '0, md_cause = '0, md_epc = '0, md_rpc = '0;
    logic        md_flush = 1'b0;

    cp0_trap_ctrl dut (
        .clk(clk), .rst(rst), .m_valid(m_valid), .pc_m(pc_m), .bd_m(bd_m),
        .exc_m(exc_m), .exccode_m(exccode_m), .eret_m(eret_m), .hw_int(hw_int),
        .mtc0_m(mtc0_m), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
        .cp0_rdata(cp0_rdata), .flush(flush), .redirect_en(redirect_en),
        .redirect_pc(redirect_pc), .epc_out(epc_out), .in_trap(in_trap)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_read(input logic [4:0] a);
        case (a)
            5'd12:   return md_sr;
            5'd13:   return md_cause;
            5'd14:   return md_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_step();
        logic pend, was_flush;
        if (!rst) begin
            md_sr = 0; md_cause = 0; md_epc = 0; md_rpc = 0; md_flush = 0;
        end else begin
            pend = ((md_cause[15:10] & md_sr[15:10]) != 6'd0) && md_sr[0] && !md_sr[1];
            was_flush = md_flush;
            md_flush = 1'b0;
            if (!was_flush && m_valid) begin
                if (pend || exc_m) begin
                    md_epc   = pc_m - (bd_m ? 32'd4 : 32'd0);
                    md_cause = (bd_m ? 32'h8000_0000 : 32'h0) |
                               (pend ? 32'h0 : ({27'b0, exccode_m} << 2));
                    md_sr    = md_sr | 32'h2;
                    md_flush = 1'b1;
                    md_rpc   = HANDLER;
                end else if (eret_m) begin
                    md_sr    = md_sr & ~32'h2;
                    md_flush = 1'b1;
                    md_rpc   = md_epc;
                end else if (mtc0_m) begin
                    if (cp0_addr == 5'd12) md_sr = cp0_wdata & 32'h0000_FC03;
                    if (cp0_addr == 5'd14) md_epc = cp0_wdata & 32'hFFFF_FFFC;
                end
            end
            md_cause = (md_cause & ~32'h0000_FC00) | ({26'b0, hw_int} << 10);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m_valid = 0; bd_m = 0; exc_m = 0; eret_m = 0; mtc0_m = 0; exccode_m = 0;
    endtask

    task automatic do_mtc0(input logic [4:0] a, input logic [31:0] d);
        idle(); m_valid = 1; mtc0_m = 1; cp0_addr = a; cp0_wdata = d;
        tick();
        idle();
    endtask

    task automatic test_reset();
        rst = 0; m_valid = 1; exc_m = 1; hw_int = 6'h3F; pc_m = 32'h1111;
        tick();
        rst = 1; idle(); hw_int = 0;
        vectors++; if (flush !== 1'b0 || redirect_en !== 1'b0) begin miscompares++; $display("FAIL reset_flush: got %b/%b want 0/0", flush, redirect_en); end
        vectors++; if (redirect_pc !== 32'h0) begin miscompares++; $display("FAIL reset_rpc: got %h want 0", redirect_pc); end
        vectors++; if (epc_out !== 32'h0 || in_trap !== 1'b0) begin miscompares++; $display("FAIL reset_epc_trap: got %h/%b want 0/0", epc_out, in_trap); end
        cp0_addr = 5'd12; #1;
        vectors++; if (cp0_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_sr: got %h want 0", cp0_rdata); end
        cp0_addr = 5'd13; #1;
        vectors++; if (cp0_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_cause: got %h want 0", cp0_rdata); end
        cp0_addr = 5'd15; #1;
        vectors++; if (cp0_rdata !== PRID) begin miscompares++; $display("FAIL reset_prid: got %h want %h", cp0_rdata, PRID); end
    endtask

    task automatic test_interrupt();
        do_mtc0(5'd12, 32'h0000_0401);
        cp0_addr = 5'd12; #1;
        vectors++; if (cp0_rdata !== 32'h0000_0401) begin miscompares++; $display("FAIL int_sr_write: got %h want 00000401", cp0_rdata); end
        hw_int = 6'b000001; tick();          // IP sampling cycle, no valid M
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL int_no_early_flush: got %b want 0", flush); end
        m_valid = 1; pc_m = 32'h3010; tick();
        idle();
        vectors++; if (flush !== 1'b1 || redirect_en !== 1'b1) begin miscompares++; $display("FAIL int_flush: got %b/%b want 1/1", flush, redirect_en); end
        vectors++; if (redirect_pc !== HANDLER) begin miscompares++; $display("FAIL int_rpc: got %h want %h", redirect_pc, HANDLER); end
        vectors++; if (epc_out !== 32'h3010 || in_trap !== 1'b1) begin miscompares++; $display("FAIL int_epc: got %h/%b want 00003010/1", epc_out, in_trap); end
        cp0_addr = 5'd13; #1;
        vectors++; if (cp0_rdata !== 32'h0000_0400) begin miscompares++; $display("FAIL int_cause: got %h want 00000400", cp0_rdata); end
        tick();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL int_one_cycle: got %b want 0", flush); end
    endtask

    task automatic test_eret();
        m_valid = 1; eret_m = 1; pc_m = 32'h4200; tick();
        // This is the FLUSH cycle: an interrupt is pending but must be ignored.
        idle(); m_valid = 1; pc_m = 32'h5000;
        vectors++; if (flush !== 1'b1 || redirect_pc !== 32'h3010) begin miscompares++; $display("FAIL eret_redirect: got %b/%h want 1/00003010", flush, redirect_pc); end
        vectors++; if (in_trap !== 1'b0) begin miscompares++; $display("FAIL eret_exl: got %b want 0", in_trap); end
        tick();
        vectors++; if (flush !== 1'b0 || epc_out !== 32'h3010) begin miscompares++; $display("FAIL eret_flush_ignore: got %b/%h want 0/00003010", flush, epc_out); end
        pc_m = 32'h3100; tick();
        idle();
        vectors++; if (flush !== 1'b1 || epc_out !== 32'h3100 || redirect_pc !== HANDLER) begin miscompares++; $display("FAIL eret_reint: got %b/%h/%h want 1/00003100/%h", flush, epc_out, redirect_pc, HANDLER); end
        hw_int = 0; tick(); tick();
    endtask

    task automatic test_delay_slot_exc();
        m_valid = 1; exc_m = 1; exccode_m = 5'd12; bd_m = 1; pc_m = 32'h3024; tick();
        idle();
        vectors++; if (flush !== 1'b1 || epc_out !== 32'h3020) begin miscompares++; $display("FAIL ds_epc: got %b/%h want 1/00003020", flush, epc_out); end
        cp0_addr = 5'd13; #1;
        vectors++; if (cp0_rdata !== 32'h8000_0030) begin miscompares++; $display("FAIL ds_cause: got %h want 80000030", cp0_rdata); end
        tick();
        vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL ds_one_cycle: got %b want 0", flush); end
    endtask

    task automatic test_masking();
        logic [31:0] masks [3] = '{32'h0000_0403, 32'h0000_0400, 32'h0000_0801};
        for (int i = 0; i < 3; i++) begin
            hw_int = 0;
            do_mtc0(5'd12, masks[i]);
            hw_int = 6'b000001; m_valid = 1; pc_m = 32'h6000 + 32'(i * 16);
            for (int k = 0; k < 2; k++) begin
                tick();
                vectors++; if (flush !== 1'b0) begin miscompares++; $display("FAIL mask_%0d: got flush %b want 0", i, flush); end
            end
            idle();
        end
        hw_int = 0; tick();
        m_valid = 1; exc_m = 1; exccode_m = 5'd4; pc_m = 32'h2000;
        mtc0_m = 1; cp0_addr = 5'd14; cp0_wdata = 32'h1234_5677; tick();
        idle();
        vectors++; if (flush !== 1'b1 || epc_out !== 32'h2000) begin miscompares++; $display("FAIL exc_beats_mtc0: got %b/%h want 1/00002000", flush, epc_out); end
        tick();
        do_mtc0(5'd14, 32'h1234_5677);
        cp0_addr = 5'd14; #1;
        vectors++; if (cp0_rdata !== 32'h1234_5674) begin miscompares++; $display("FAIL epc_align: got %h want 12345674", cp0_rdata); end
        // Same-cycle MFC0 of an MTC0 target sees the old value.
        m_valid = 1; mtc0_m = 1; cp0_addr = 5'd14; cp0_wdata = 32'hABCD_0000; #1;
        vectors++; if (cp0_rdata !== 32'h1234_5674) begin miscompares++; $display("FAIL mfc0_bypass: got %h want 12345674", cp0_rdata); end
        tick(); idle();
        vectors++; if (cp0_rdata !== 32'hABCD_0000) begin miscompares++; $display("FAIL mfc0_next: got %h want abcd0000", cp0_rdata); end
    endtask

    task automatic test_simultaneous();
        hw_int = 6'b000001;
        do_mtc0(5'd12, 32'h0000_0401);
        m_valid = 1; exc_m = 1; eret_m = 1; exccode_m = 5'd7; pc_m = 32'h3300; tick();
        vectors++; if (flush !== 1'b1 || epc_out !== 32'h3300) begin miscompares++; $display("FAIL simul_take: got %b/%h want 1/00003300", flush, epc_out); end
        cp0_addr = 5'd13; #1;
        vectors++; if (cp0_rdata[6:2] !== 5'd0) begin miscompares++; $display("FAIL simul_exccode: got %0d want 0", cp0_rdata[6:2]); end
        eret_m = 0; exccode_m = 5'd9; pc_m = 32'h9998; tick();   // trigger during FLUSH
        vectors++; if (flush !== 1'b0 || epc_out !== 32'h3300) begin miscompares++; $display("FAIL flush_ignore: got %b/%h want 0/00003300", flush, epc_out); end
        m_valid = 0; tick();
        idle();
        vectors++; if (flush !== 1'b0 || epc_out !== 32'h3300) begin miscompares++; $display("FAIL mvalid0: got %b/%h want 0/00003300", flush, epc_out); end
        hw_int = 0; tick();
    endtask

    task automatic test_reset_mid_flush();
        m_valid = 1; exc_m = 1; exccode_m = 5'd3; pc_m = 32'h7000; tick();
        idle();
        vectors++; if (flush !== 1'b1) begin miscompares++; $display("FAIL rmf_pre: got flush %b want 1", flush); end
        rst = 0; tick();
        rst = 1;
        vectors++; if (flush !== 1'b0 || redirect_en !== 1'b0 || redirect_pc !== 32'h0) begin miscompares++; $display("FAIL rmf_outputs: got %b/%b/%h want 0/0/0", flush, redirect_en, redirect_pc); end
        vectors++; if (epc_out !== 32'h0 || in_trap !== 1'b0) begin miscompares++; $display("FAIL rmf_regs: got %h/%b want 0/0", epc_out, in_trap); end
        cp0_addr = 5'd13; #1;
        vectors++; if (cp0_rdata !== 32'h0) begin miscompares++; $display("FAIL rmf_cause: got %h want 0", cp0_rdata); end
        cp0_addr = 5'd15; #1;
        vectors++; if (cp0_rdata !== PRID) begin miscompares++; $display("FAIL rmf_prid: got %h want %h", cp0_rdata, PRID); end
    endtask

    task automatic test_random();
        logic [4:0] addrs [6] = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd0, 5'd20};
        for (int n = 0; n < 400; n++) begin
            rst       = ($urandom_range(99) >= 2);
            m_valid   = ($urandom_range(99) < 75);
            exc_m     = ($urandom_range(99) < 12);
            eret_m    = ($urandom_range(99) < 10);
            mtc0_m    = ($urandom_range(99) < 30);
            bd_m      = 1'($urandom_range(1));
            exccode_m = 5'($urandom);
            pc_m      = ($urandom_range(9) == 0) ? 32'h0 : {$urandom, 2'b00} >> 2 << 2;
            cp0_addr  = addrs[$urandom_range(5)];
            cp0_wdata = ($urandom_range(1) == 1) ? 32'h0000_FC01 : $urandom;
            if ($urandom_range(7) == 0) hw_int = 6'($urandom);
            #1;
            vectors++; if (cp0_rdata !== model_read(cp0_addr)) begin miscompares++; $display("FAIL rnd_rdata[%0d] addr %0d: got %h want %h", n, cp0_addr, cp0_rdata, model_read(cp0_addr)); end
            tick();
            vectors++; if (flush !== md_flush || redirect_en !== md_flush) begin miscompares++; $display("FAIL rnd_flush[%0d]: got %b/%b want %b", n, flush, redirect_en, md_flush); end
            if (md_flush) begin
                vectors++; if (redirect_pc !== md_rpc) begin miscompares++; $display("FAIL rnd_rpc[%0d]: got %h want %h", n, redirect_pc, md_rpc); end
            end
            vectors++; if (epc_out !== md_epc || in_trap !== md_sr[1]) begin miscompares++; $display("FAIL rnd_epc_trap[%0d]: got %h/%b want %h/%b", n, epc_out, in_trap, md_epc, md_sr[1]); end
        end
        rst = 1; idle();
    endtask

    initial begin
        test_reset();
        test_interrupt();
        test_eret();
        test_delay_slot_exc();
        test_masking();
        test_simultaneous();
        test_reset_mid_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/cp0_trap_ctrl.md
Name: cp0_trap_ctrl

Overview:
- Coprocessor-0 style trap controller for the five-stage pipeline: owns SR, Cause, EPC and PRId.
- Decides interrupt, exception and ERET at the M stage.
- Sequences the pipeline through a one-cycle flush/redirect so that F/D/E/M are cleared and the PC is reloaded.
- Also serves MFC0 reads and MTC0 writes issued from M.

Parameters:
- HANDLER_PC, 32'h0000_4180, trap vector loaded on interrupt/exception.
- PRID_VAL, 32'h0000_0601, read-only value of register 15.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-low reset; one clock, reset sampled on rising edge of clk.
- m_valid  in  1  M stage holds a real instruction (not a bubble).
- pc_m  in  32  PC of the M-stage instruction.
- bd_m  in  1  M instruction sits in a branch delay slot.
- exc_m  in  1  M instruction raised a synchronous exception.
- exccode_m  in  5  exception code accompanying exc_m.
- eret_m  in  1  M instruction is ERET.
- hw_int  in  6  external interrupt lines, level-sensitive.
- mtc0_m  in  1  M instruction is MTC0.
- cp0_addr  in  5  CP0 register number for MTC0/MFC0.
- cp0_wdata  in  32  MTC0 write data.
- cp0_rdata  out  32  MFC0 read data, combinational on cp0_addr.
- flush  out  1  clear F/D/E/M pipeline registers and veto M memwrite/regwrite.
- redirect_en  out  1  PC loads redirect_pc instead of npc.
- redirect_pc  out  32  target PC.
- epc_out  out  32  current EPC.
- in_trap  out  1  mirrors SR.EXL.

Behaviour:
- Registers:
  - SR (addr 12): IM[15:10], EXL[1], IE[0]; all other bits read 0.
  - Cause (addr 13): BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
    - IP is a copy of hw_int, registered every cycle.
  - EPC (addr 14): 32 bits.
  - PRId (addr 15): PRID_VAL.
  - Any other address reads 0.
- Reset (rst=0 at a clock edge):
  - SR=0, Cause=0, EPC=0, state=RUN.
  - flush=0, redirect_en=0, redirect_pc=0, in_trap=0.
  - Reset overrides everything, including a trap that is mid-flush.
- int_pend = |(Cause.IP & SR.IM) & SR.IE & ~SR.EXL.
- States:
  - RUN: triggers are evaluated each cycle; only one trigger is taken per cycle.
  - FLUSH: lasts exactly 1 cycle with flush=1, redirect_en=1, redirect_pc held; no trigger accepted; next state is RUN.
- Trigger priority in RUN (m_valid=1 required for all triggers):
  1. Interrupt, when int_pend=1:
     - ExcCode=0.
     - Go to FLUSH with redirect_pc=HANDLER_PC.
  2. Exception, when exc_m=1:
     - ExcCode=exccode_m.
     - Go to FLUSH with redirect_pc=HANDLER_PC.
  3. ERET, when eret_m=1:
     - EXL<=0.
     - Go to FLUSH with redirect_pc=EPC.
  4. MTC0, when mtc0_m=1:
     - Register write at the edge.
     - No state change.
- On an interrupt or exception, the following update at the trigger edge:
  - EPC <= bd_m ? pc_m-4 : pc_m.
  - Cause.BD <= bd_m.
  - SR.EXL <= 1.
- A trap outranks a simultaneous MTC0: the write is dropped (the instruction re-executes after return).
- ERET does not update EPC or Cause.
- MTC0 write rules:
  - SR: writes IM, EXL and IE.
  - EPC: bits[1:0] forced to 0.
  - Cause: software writes are ignored.
  - PRId: writes are ignored.
- Latency:
  - The trigger is sampled in cycle N.
  - flush, redirect_en and redirect_pc are registered outputs, valid in cycle N+1 only.
  - epc_out and in_trap reflect the new values from N+1.
- m_valid=0: no trigger and no write; Cause.IP still samples hw_int, so an interrupt waits for the next valid M instruction.
- During FLUSH:
  - m_valid, exc_m and the other M-stage inputs are ignored, because M is being cleared.
  - Cause.IP keeps sampling hw_int.
- Bypass: MFC0 in the same cycle as an MTC0 to the same address returns the old value; the new value is visible the next cycle.
- EPC arithmetic wraps modulo 2^32: pc_m=0 with bd_m=1 gives EPC=32'hFFFF_FFFC.

Test Plan:
1. Interrupt:
   - Stimulus: reset; MTC0 SR=32'h0000_0401 (IM[10]=1, IE=1); hw_int=6'b000001 asserted with m_valid=1, pc_m=32'h3010.
   - Required: after IP sampling, the first valid cycle gives, next cycle, flush=1 and redirect_pc=32'h4180 for one cycle; EPC=32'h3010, ExcCode=0, in_trap=1.
2. Delay-slot exception:
   - Stimulus: exc_m=1, exccode_m=5'd12, bd_m=1, pc_m=32'h3024.
   - Required: EPC=32'h3020, Cause=32'h8000_0030 with IP=0, flush pulse exactly 1 cycle.
3. ERET round trip:
   - Stimulus: after scenario 1, eret_m=1.
   - Required: next cycle redirect_pc=32'h3010, flush=1; SR.EXL=0, in_trap=0.
   - Required: a further interrupt is then taken again.
4. Masking and nesting:
   - Stimulus: EXL=1 or IE=0 or IM bit clear, with hw_int asserted.
   - Required: no flush.
   - Stimulus: exc_m and mtc0_m (EPC, 32'h1234_5677) in the same cycle.
   - Required: exception wins, EPC=pc_m.
   - Stimulus: MTC0 alone to EPC with 32'h1234_5677.
   - Required: EPC reads 32'h1234_5674.
5. Simultaneous events:
   - Stimulus: int_pend, exc_m and eret_m all in one cycle.
   - Required: treated as an interrupt (ExcCode=0).
   - Stimulus: a trigger during the FLUSH cycle.
   - Required: ignored.
   - Stimulus: m_valid=0 with exc_m=1.
   - Required: no action.
6. Reset mid-flush:
   - Stimulus: rst=0 in the FLUSH cycle.
   - Required: next cycle flush=0, redirect_en=0, all registers 0, PRId read still returns 32'h0000_0601.
